// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one 8-bit external memory between two requesters.
// Each access runs IDLE -> ACCESS -> DONE, and every output is a register.
module mem_arbiter #(
   parameter int WIDTH  = 8,
   parameter int RD_LAT = 1,
   parameter int RR_EN  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             req0,
   input  logic             we0,
   input  logic [WIDTH-1:0] adr0,
   input  logic [WIDTH-1:0] wdata0,
   output logic             gnt0,
   output logic             done0,
   output logic [WIDTH-1:0] rdata0,
   input  logic             req1,
   input  logic             we1,
   input  logic [WIDTH-1:0] adr1,
   input  logic [WIDTH-1:0] wdata1,
   output logic             gnt1,
   output logic             done1,
   output logic [WIDTH-1:0] rdata1,
   output logic             mem_we,
   output logic [WIDTH-1:0] mem_adr,
   output logic [WIDTH-1:0] mem_wdata,
   input  logic [WIDTH-1:0] mem_rdata,
   output logic             busy
);

   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

   localparam logic [1:0] LAST_CNT = 2'(RD_LAT - 1);

   if (RD_LAT < 1 || RD_LAT > 3) begin : g_bad_rd_lat
      $fatal(1, "mem_arbiter: RD_LAT=%0d is outside the legal range 1..3", RD_LAT);
   end

   state_t           state_q;
   logic [1:0]       cnt_q;
   logic             last_q;
   logic             owner_q;
   logic             gnt0_q, gnt1_q, done0_q, done1_q, busy_q, mem_we_q;
   logic [WIDTH-1:0] rdata0_q, rdata1_q, mem_adr_q, mem_wdata_q;
   logic             pick1_d;

   // Port 1 wins when it is alone, or on a tie when round-robin says port 0 went last.
   always_comb begin
      pick1_d = req1 && (!req0 || ((RR_EN != 0) && !last_q));
   end

   // mem_we_q doubles as the write flag: it is high only in a write's single ACCESS cycle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         cnt_q       <= 2'd0;
         last_q      <= 1'b1;
         owner_q     <= 1'b0;
         gnt0_q      <= 1'b0;
         gnt1_q      <= 1'b0;
         done0_q     <= 1'b0;
         done1_q     <= 1'b0;
         busy_q      <= 1'b0;
         mem_we_q    <= 1'b0;
         rdata0_q    <= '0;
         rdata1_q    <= '0;
         mem_adr_q   <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req0 || req1) begin
                  owner_q     <= pick1_d;
                  last_q      <= pick1_d;
                  mem_we_q    <= pick1_d ? we1 : we0;
                  mem_adr_q   <= pick1_d ? adr1 : adr0;
                  mem_wdata_q <= pick1_d ? wdata1 : wdata0;
                  gnt0_q      <= !pick1_d;
                  gnt1_q      <= pick1_d;
                  cnt_q       <= 2'd0;
                  busy_q      <= 1'b1;
                  state_q     <= ACCESS;
               end
            end
            ACCESS: begin
               gnt0_q <= 1'b0;
               gnt1_q <= 1'b0;
               if (mem_we_q || cnt_q == LAST_CNT) begin
                  mem_we_q <= 1'b0;
                  if (!mem_we_q) begin
                     if (owner_q) rdata1_q <= mem_rdata;
                     else         rdata0_q <= mem_rdata;
                  end
                  done0_q <= !owner_q;
                  done1_q <= owner_q;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 2'd1;
               end
            end
            DONE: begin
               done0_q <= 1'b0;
               done1_q <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign done0     = done0_q;
   assign done1     = done1_q;
   assign rdata0    = rdata0_q;
   assign rdata1    = rdata1_q;
   assign mem_we    = mem_we_q;
   assign mem_adr   = mem_adr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: dut 0 is RD_LAT=3 round-robin, dut 1 is RD_LAT=1 fixed priority,
// each with its own behavioural memory whose read latency matches its RD_LAT.
module tb_mem_arbiter;

   typedef struct {
      int         dutIdx;
      int         port;
      bit         we;
      logic [7:0] adr;
      logic [7:0] wdata;
      logic [7:0] expData;
   } vec_t;

   typedef struct {
      int         port;
      bit         isRead;
      logic [7:0] data;
   } exp_t;

   logic       clk = 1'b0;
   logic       rstN   [2];
   logic       req0   [2];
   logic       we0    [2];
   logic       req1   [2];
   logic       we1    [2];
   logic [7:0] adr0   [2];
   logic [7:0] wdata0 [2];
   logic [7:0] adr1   [2];
   logic [7:0] wdata1 [2];
   logic       gnt0   [2];
   logic       gnt1   [2];
   logic       done0  [2];
   logic       done1  [2];
   logic       memWe  [2];
   logic       busy   [2];
   logic [7:0] rdata0 [2];
   logic [7:0] rdata1 [2];
   logic [7:0] memAdr [2];
   logic [7:0] memWdata [2];

   exp_t sbq0[$];
   exp_t sbq1[$];
   int   testsRun = 0;
   int   testsFailed = 0;

   always #5 clk = ~clk;

   for (genvar k = 0; k < 2; k++) begin : g_dut
      localparam int LAT = (k == 0) ? 3 : 1;
      localparam int RR  = (k == 0) ? 1 : 0;
      logic [7:0] mem [256];
      logic [7:0] pipe0, pipe1, rd;

      initial begin
         for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'h3C;
      end

      // Read data shows up LAT cycles after the address settles; earlier cycles carry stale data.
      always @(posedge clk) begin
         if (memWe[k]) mem[memAdr[k]] <= memWdata[k];
         pipe0 <= mem[memAdr[k]];
         pipe1 <= pipe0;
      end

      assign rd = (LAT == 1) ? mem[memAdr[k]] : pipe1;

      mem_arbiter #(.WIDTH(8), .RD_LAT(LAT), .RR_EN(RR)) u_dut (
         .clk(clk), .reset(rstN[k]),
         .req0(req0[k]), .we0(we0[k]), .adr0(adr0[k]), .wdata0(wdata0[k]),
         .gnt0(gnt0[k]), .done0(done0[k]), .rdata0(rdata0[k]),
         .req1(req1[k]), .we1(we1[k]), .adr1(adr1[k]), .wdata1(wdata1[k]),
         .gnt1(gnt1[k]), .done1(done1[k]), .rdata1(rdata1[k]),
         .mem_we(memWe[k]), .mem_adr(memAdr[k]), .mem_wdata(memWdata[k]),
         .mem_rdata(rd), .busy(busy[k])
      );
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
      testsRun++;
      if (act !== expVal) begin
         testsFailed++;
         $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, expVal, $time);
      end
   endtask

   task automatic setPort(input int k, input int port, input logic r, input logic w,
                          input logic [7:0] a, input logic [7:0] d);
      if (port == 0) begin
         req0[k] = r; we0[k] = w; adr0[k] = a; wdata0[k] = d;
      end else begin
         req1[k] = r; we1[k] = w; adr1[k] = a; wdata1[k] = d;
      end
   endtask

   task automatic pushExp(input int k, input int port, input bit isRead, input logic [7:0] data);
      exp_t e;
      e.port = port; e.isRead = isRead; e.data = data;
      if (k == 0) sbq0.push_back(e);
      else        sbq1.push_back(e);
   endtask

   function automatic int latOf(input int k);
      return (k == 0) ? 3 : 1;
   endfunction

   function automatic logic gntOf(input int k, input int port);
      return (port == 0) ? gnt0[k] : gnt1[k];
   endfunction

   function automatic logic doneOf(input int k, input int port);
      return (port == 0) ? done0[k] : done1[k];
   endfunction

   // Every done pops the oldest expected access for that dut and checks port and read data.
   task automatic monitorDut(input int k);
      exp_t e;
      logic anyDone;
      int   port;
      int   depth;
      anyDone = done0[k] | done1[k];
      if (!rstN[k] || !anyDone) return;
      port  = done1[k] ? 1 : 0;
      depth = (k == 0) ? sbq0.size() : sbq1.size();
      if (depth == 0) begin
         checkOutput("sbSpuriousDone", anyDone, 0);
         return;
      end
      if (k == 0) e = sbq0.pop_front();
      else        e = sbq1.pop_front();
      checkOutput("sbPort", port, e.port);
      if (e.isRead) checkOutput("sbRdata", (port == 1) ? rdata1[k] : rdata0[k], e.data);
   endtask

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) monitorDut(k);
   end

   task automatic applyStimulus(input vec_t v);
      int         k, gntAt, doneAt, expDone;
      logic [7:0] prev0, prev1, exp0, exp1;
      k = v.dutIdx;
      @(negedge clk);
      prev0 = rdata0[k];
      prev1 = rdata1[k];
      setPort(k, v.port, 1'b1, v.we, v.adr, v.wdata);
      pushExp(k, v.port, !v.we, v.expData);
      gntAt  = -1;
      doneAt = -1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) begin
            checkOutput("busy", busy[k], 1);
            checkOutput("memWe", memWe[k], v.we);
            checkOutput("memAdr", memAdr[k], v.adr);
            if (v.we) checkOutput("memWdata", memWdata[k], v.wdata);
         end
         if (c == 2 && v.we) checkOutput("memWeOneCycle", memWe[k], 0);
         if (gntOf(k, v.port) && gntAt < 0) gntAt = c;
         if (doneOf(k, v.port)) begin
            doneAt = c;
            break;
         end
      end
      setPort(k, v.port, 1'b0, 1'b0, 8'h00, 8'h00);
      expDone = v.we ? 2 : 1 + latOf(k);
      exp0 = (v.port == 0 && !v.we) ? v.expData : prev0;
      exp1 = (v.port == 1 && !v.we) ? v.expData : prev1;
      checkOutput("gntLatency", gntAt, 1);
      checkOutput("doneLatency", doneAt, expDone);
      checkOutput("rdata0", rdata0[k], exp0);
      checkOutput("rdata1", rdata1[k], exp1);
   endtask

   // Both ports hold write requests; port 0 optionally drops out after its Nth grant.
   task automatic holdBoth(input int k, input int drop0After, input logic [3:0] expOrder, input string tag);
      int order[$];
      @(negedge clk);
      setPort(k, 0, 1'b1, 1'b1, 8'h50, 8'h11);
      setPort(k, 1, 1'b1, 1'b1, 8'h60, 8'h22);
      for (int i = 0; i < 4; i++) pushExp(k, int'(expOrder[i]), 1'b0, 8'h00);
      for (int c = 0; c < 60 && order.size() < 4; c++) begin
         @(negedge clk);
         if (gnt0[k]) order.push_back(0);
         if (gnt1[k]) order.push_back(1);
         if (gnt0[k] && order.size() == drop0After) req0[k] = 1'b0;
      end
      req0[k] = 1'b0;
      req1[k] = 1'b0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 4; i++)
         checkOutput(tag, (i < order.size()) ? order[i] : -1, int'(expOrder[i]));
   endtask

   initial begin
      vec_t vecs[11];
      int   gntAt, doneAt;
      logic doneSeen;

      vecs[0]  = '{0, 1, 1'b1, 8'h10, 8'hA5, 8'h00};
      vecs[1]  = '{0, 0, 1'b0, 8'h10, 8'h00, 8'hA5};
      vecs[2]  = '{0, 1, 1'b0, 8'h10, 8'h00, 8'hA5};
      vecs[3]  = '{0, 0, 1'b1, 8'h20, 8'h5A, 8'h00};
      vecs[4]  = '{0, 1, 1'b0, 8'h33, 8'h00, 8'h0F};
      vecs[5]  = '{0, 1, 1'b0, 8'h20, 8'h00, 8'h5A};
      vecs[6]  = '{1, 1, 1'b1, 8'h10, 8'hA5, 8'h00};
      vecs[7]  = '{1, 0, 1'b0, 8'h10, 8'h00, 8'hA5};
      vecs[8]  = '{1, 1, 1'b0, 8'h44, 8'h00, 8'h78};
      vecs[9]  = '{1, 0, 1'b1, 8'hFF, 8'h01, 8'h00};
      vecs[10] = '{1, 0, 1'b0, 8'hFF, 8'h00, 8'h01};

      for (int k = 0; k < 2; k++) begin
         rstN[k] = 1'b0;
         setPort(k, 0, 1'b0, 1'b0, 8'h00, 8'h00);
         setPort(k, 1, 1'b0, 1'b0, 8'h00, 8'h00);
      end
      #2;
      for (int k = 0; k < 2; k++) begin
         checkOutput("rstCtrl", {gnt0[k], gnt1[k], done0[k], done1[k], memWe[k], busy[k]}, 0);
         checkOutput("rstMem", {memAdr[k], memWdata[k]}, 0);
         checkOutput("rstRdata", {rdata0[k], rdata1[k]}, 0);
      end
      @(negedge clk);
      rstN[0] = 1'b1;
      rstN[1] = 1'b1;

      for (int i = 0; i < 11; i++) applyStimulus(vecs[i]);

      holdBoth(0, -1, 4'b1010, "rrOrder");
      holdBoth(1, 3, 4'b1000, "fixedOrder");

      $display("[TB] late request: port 1 arrives during port 0 read");
      @(negedge clk);
      setPort(0, 0, 1'b1, 1'b0, 8'h10, 8'h00);
      pushExp(0, 0, 1'b1, 8'hA5);
      gntAt  = -1;
      doneAt = -1;
      for (int c = 1; c <= 20; c++) begin
         @(negedge clk);
         if (c == 1) begin
            setPort(0, 1, 1'b1, 1'b1, 8'h70, 8'h33);
            pushExp(0, 1, 1'b0, 8'h00);
         end
         if (gnt1[0] && gntAt < 0) gntAt = c;
         if (done0[0]) begin
            doneAt = c;
            req0[0] = 1'b0;
         end
         if (done1[0]) begin
            req1[0] = 1'b0;
            break;
         end
      end
      req0[0] = 1'b0;
      req1[0] = 1'b0;
      checkOutput("lateDone0", doneAt, 4);
      checkOutput("lateGnt1", gntAt, 6);

      $display("[TB] req dropped after grant");
      @(negedge clk);
      setPort(0, 0, 1'b1, 1'b0, 8'h20, 8'h00);
      pushExp(0, 0, 1'b1, 8'h5A);
      doneAt = -1;
      for (int c = 1; c <= 10; c++) begin
         @(negedge clk);
         if (c == 1) begin
            checkOutput("dropGnt0", gnt0[0], 1);
            req0[0] = 1'b0;
         end
         if (done0[0]) begin
            doneAt = c;
            break;
         end
      end
      checkOutput("dropDone0", doneAt, 4);
      checkOutput("dropRdata0", rdata0[0], 8'h5A);

      $display("[TB] reset in the middle of a read");
      @(negedge clk);
      setPort(0, 0, 1'b1, 1'b0, 8'h33, 8'h00);
      repeat (2) @(negedge clk);
      checkOutput("midBusy", busy[0], 1);
      rstN[0] = 1'b0;
      req0[0] = 1'b0;
      #1;
      checkOutput("abortCtrl", {gnt0[0], gnt1[0], done0[0], done1[0], memWe[0], busy[0]}, 0);
      checkOutput("abortMem", {memAdr[0], memWdata[0]}, 0);
      checkOutput("abortRdata", {rdata0[0], rdata1[0]}, 0);
      doneSeen = 1'b0;
      repeat (2) begin
         @(negedge clk);
         doneSeen = doneSeen | done0[0];
      end
      rstN[0] = 1'b1;
      repeat (4) begin
         @(negedge clk);
         doneSeen = doneSeen | done0[0];
      end
      checkOutput("abortNoDone", doneSeen, 0);
      applyStimulus('{0, 0, 1'b0, 8'h10, 8'h00, 8'hA5});

      repeat (4) @(negedge clk);
      checkOutput("sbLeft0", sbq0.size(), 0);
      checkOutput("sbLeft1", sbq1.size(), 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares the single 8-bit external memory between two requesters. Port 0 is the mips core's memory interface; port 1 is a loader/debug master that preloads programs and inspects results. The block sits between the requesters and exmemory. It arbitrates, sequences each access through a small state machine, waits out the memory read latency, and returns read data with a completion pulse.

Parameters:
WIDTH, 8, address and data width
RD_LAT, 1, cycles from mem_adr stable to mem_rdata valid; legal range 1..3
RR_EN, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 always wins

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-low reset
req0  input  1  port 0 access request; held high until done0
we0  input  1  port 0 write enable (1 = write, 0 = read)
adr0  input  WIDTH  port 0 address
wdata0  input  WIDTH  port 0 write data
gnt0  output  1  one-cycle pulse: port 0 access accepted
done0  output  1  one-cycle pulse: port 0 access complete
rdata0  output  WIDTH  port 0 read data; valid while done0 is high, held until the next port 0 read completes
req1, we1, adr1, wdata1, gnt1, done1, rdata1  same as port 0, for port 1
mem_we  output  1  memory write strobe
mem_adr  output  WIDTH  memory address
mem_wdata  output  WIDTH  memory write data
mem_rdata  input  WIDTH  memory read data
busy  output  1  high whenever state is not IDLE

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cnt=0, last=1 (port 0 wins the first contest).
  - All outputs 0: gnt*, done*, rdata*, mem_we, mem_adr, mem_wdata, busy.
  - Asserting reset mid-access aborts it. No done is issued, and mem_we drops immediately.
- All outputs are registered.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Any req: pick a winner, latch its we/adr/wdata into mem_we/mem_adr/mem_wdata, set cnt=0, go to ACCESS.
  - Arbitration with both req high: RR_EN=1 gives the port that is not `last`; RR_EN=0 gives port 0.
  - A single requester always wins.
  - `last` updates to the winner.
- ACCESS, first cycle: gnt of the winner is high for exactly this cycle. busy=1.
- ACCESS, write: mem_we=1 for exactly one cycle, then next state is DONE.
- ACCESS, read:
  - mem_we=0, and mem_adr is held for RD_LAT cycles (cnt counts 0..RD_LAT-1).
  - On the last cycle, mem_rdata is captured into the winner's rdata.
  - Next state is DONE.
- DONE: done of the winner is high for one cycle, mem_we=0, then next state is IDLE.
- Latency, with req sampled in IDLE at edge t:
  - Write: gnt at t+1, done at t+2.
  - Read: gnt at t+1, done at t+1+RD_LAT.
  - Minimum request-to-request spacing per port is 3 cycles (write) or 2+RD_LAT cycles (read).
- Requester handshake:
  - The requester must hold req/we/adr/wdata stable until done.
  - Deassertion of req after gnt is ignored; the latched access completes and done still pulses.
  - The requester must drop req in the cycle after done, or it is treated as a new request.
- A req that arrives while busy waits. It is arbitrated when the state machine is next in IDLE.
- The losing requester's signals are never sampled during another port's access.
- Fairness with RR_EN=1: with both ports continuously requesting, grants alternate 0,1,0,1. No port waits more than one foreign access.
- mem_adr and mem_wdata hold their last values in IDLE. mem_we is 0 in every state except the write ACCESS cycle.
- rdata of the non-winning port never changes.
- A write never modifies either rdata.
- Illegal RD_LAT (0 or greater than 3) is a parameter error; simulation must $display and $finish.

Test Plan:
- Reset then single write: req1=1, we1=1, adr1=8'h10, wdata1=8'hA5 -> gnt1 at t+1, mem_we=1 with mem_adr=8'h10 and mem_wdata=8'hA5 for exactly one cycle, done1 at t+2; rdata0=rdata1=0.
- Read, RD_LAT=1 and RD_LAT=3: port 0 reads adr 8'h10 after the write above -> done0 at t+2 and t+4 respectively, rdata0=8'hA5; rdata1 unchanged.
- Simultaneous requests, RR_EN=1, both held for 4 accesses -> grant order 0,1,0,1. With RR_EN=0 and both held -> port 0 is granted every time, and port 1 only when req0 is low in IDLE.
- Late request: req1 rises during port 0's ACCESS -> no gnt1 until port 0's DONE has passed; gnt1 appears exactly 2 cycles after done0 (one IDLE cycle in between).
- Drop of req after gnt: req0 pulled low the cycle after gnt0 on a read -> done0 still pulses and rdata0 is updated.
- Reset mid-read: reset=0 asserted during ACCESS with RD_LAT=3 -> all outputs 0 immediately, no done0; after release, a new read of 8'h10 returns 8'hA5.
